data_sram: RTL and testbench



---
 rtl/data_sram.sv | 91 +++++++++
 tb/tb_data_sram.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_sram.sv
// data_sram: data-side SRAM responder for the EX-stage data_sram_* request port.
// Holds a word-addressed 64-bit array with byte-masked stores. Loads return the
// aligned doubleword through a fixed two-stage read pipeline (MEM1 -> MEM2).
// Accesses outside the address window are dropped and flagged.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   hold              stall: freezes both read stages and blocks new requests
//   data_sram_en      request valid
//   data_sram_we      byte write strobes (0 = load)
//   data_sram_addr    byte address, bits [2:0] ignored
//   data_sram_wdata   lane-aligned store data
//   data_sram_rdata   load data (0 on error)
//   data_sram_rvalid  load result valid, two accepted cycles after the request
//   data_sram_err     out-of-window access, same slot as rvalid
module data_sram #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_we,
  input  logic [63:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        data_sram_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [63:0] mem [DEPTH];

  logic                  acc;
  logic                  is_load;
  logic                  hit;
  logic [60:0]           word_off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_addr_lsbs;

  // Window check done on word addresses; byte offset bits play no part.
  assign word_off         = data_sram_addr[63:3] - BASE_ADDR[63:3];
  assign hit              = (word_off[60:DEPTH_LOG2] == '0);
  assign idx              = word_off[DEPTH_LOG2-1:0];
  assign unused_addr_lsbs = ^data_sram_addr[2:0];

  assign acc     = data_sram_en & ~hold;
  assign is_load = (data_sram_we == 8'h00);

  // Array write is independent of reset so a store accepted during reset lands.
  always_ff @(posedge clk) begin
    if (acc && hit) begin
      for (int i = 0; i < 8; i++) begin
        if (data_sram_we[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  logic        s1_load, s1_err;
  logic [63:0] s1_data;
  logic        s2_load, s2_err;
  logic [63:0] s2_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_load <= 1'b0;
      s1_err  <= 1'b0;
      s1_data <= '0;
      s2_load <= 1'b0;
      s2_err  <= 1'b0;
      s2_data <= '0;
    end else if (!hold) begin
      // Stores and bubbles enter with load=0; misses carry err and zero data.
      s1_load <= acc & is_load;
      s1_err  <= acc & ~hit;
      s1_data <= (acc && is_load && hit) ? mem[idx] : '0;
      s2_load <= s1_load;
      s2_err  <= s1_err;
      s2_data <= s1_data;
    end
  end

  assign data_sram_rvalid = s2_load & ~s2_err;
  assign data_sram_err    = s2_err;
  assign data_sram_rdata  = s2_err ? 64'h0 : s2_data;

endmodule

// File: tb/tb_data_sram.sv
module tb_data_sram;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        data_sram_en;
  logic [7:0]  data_sram_we;
  logic [63:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  logic [63:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic        data_sram_err;

  int checks = 0;
  int fails  = 0;

  localparam logic [63:0] Base = 64'h0000_0000_8000_0000;

  data_sram #(
    .DEPTH_LOG2(12),
    .BASE_ADDR (Base)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hold            (hold),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .data_sram_rvalid(data_sram_rvalid),
    .data_sram_err   (data_sram_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rv, input logic er, input logic [63:0] rd);
    check({tag, ".rvalid"}, {63'h0, data_sram_rvalid}, {63'h0, rv});
    check({tag, ".err"},    {63'h0, data_sram_err},    {63'h0, er});
    check({tag, ".rdata"},  data_sram_rdata,           rd);
  endtask

  task automatic idle();
    data_sram_en    = 1'b0;
    data_sram_we    = 8'h00;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
  endtask

  task automatic do_load(input logic [63:0] a);
    data_sram_en    = 1'b1;
    data_sram_we    = 8'h00;
    data_sram_addr  = a;
    data_sram_wdata = '0;
  endtask

  task automatic do_store(input logic [63:0] a, input logic [7:0] we, input logic [63:0] d);
    data_sram_en    = 1'b1;
    data_sram_we    = we;
    data_sram_addr  = a;
    data_sram_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // Idle after reset: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      chk_out("reset_idle", 1'b0, 1'b0, 64'h0);
      tick();
    end

    // Full store then load in the next cycle.
    do_store(Base + 64'h10, 8'hFF, 64'h1122_3344_5566_7788);
    tick();
    do_load(Base + 64'h10);
    tick();
    idle();
    tick();
    chk_out("full_store_raw", 1'b1, 1'b0, 64'h1122_3344_5566_7788);

    // Partial store merges bytes 2 and 3.
    do_store(Base + 64'h10, 8'h0C, 64'h0000_0000_AABB_0000);
    tick();
    do_load(Base + 64'h10);
    tick();
    idle();
    tick();
    chk_out("partial_store", 1'b1, 1'b0, 64'h1122_3344_AABB_7788);

    // Preload words 0..3.
    for (int i = 0; i < 4; i++) begin
      do_store(Base + 64'(8 * i), 8'hFF, 64'(10 * (i + 1)));
      tick();
    end

    // Back-to-back loads with a hold cycle in C+3 (the load presented then is re-sent).
    do_load(Base + 64'h00);
    tick();
    do_load(Base + 64'h08);
    tick();
    chk_out("b2b_c2", 1'b1, 1'b0, 64'd10);
    do_load(Base + 64'h10);
    tick();
    chk_out("b2b_c3", 1'b1, 1'b0, 64'd20);
    hold = 1'b1;
    do_load(Base + 64'h18);
    tick();
    chk_out("b2b_hold", 1'b1, 1'b0, 64'd20);
    hold = 1'b0;
    tick();
    chk_out("b2b_c5", 1'b1, 1'b0, 64'd30);
    idle();
    tick();
    chk_out("b2b_c6", 1'b1, 1'b0, 64'd40);
    tick();
    chk_out("b2b_drain", 1'b0, 1'b0, 64'h0);

    // Out-of-window load below base and store just past the top.
    do_load(64'h0000_0000_7FFF_FFF8);
    tick();
    do_store(64'h0000_0000_8000_8000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk_out("miss_load", 1'b0, 1'b1, 64'h0);
    idle();
    tick();
    chk_out("miss_store", 1'b0, 1'b1, 64'h0);
    do_load(Base);
    tick();
    idle();
    tick();
    chk_out("word0_intact", 1'b1, 1'b0, 64'd10);

    // Reset with a load in flight; a store in the reset cycle still lands.
    do_load(Base + 64'h08);
    tick();
    rst_n = 1'b0;
    do_store(Base + 64'h18, 8'hFF, 64'h55);
    tick();
    chk_out("rst_flush", 1'b0, 1'b0, 64'h0);
    rst_n = 1'b1;
    idle();
    tick();
    chk_out("rst_after", 1'b0, 1'b0, 64'h0);
    do_load(Base + 64'h18);
    tick();
    do_load(Base + 64'h08);
    tick();
    chk_out("rst_store_kept", 1'b1, 1'b0, 64'h55);
    idle();
    tick();
    chk_out("rst_reload", 1'b1, 1'b0, 64'd20);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
